// File: rtl/ser_add_pkg.sv
// Shared definitions for the bit-serial adder:
// FSM state encoding and the default operand width.
package ser_add_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the serial adder.
// master drives operands and start; slave returns the registered result.
interface serial_add_ctrl_if
    import ser_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output start, op_a, op_b,
        input  sum, cout, busy, done
    );

    modport slave (
        input  start, op_a, op_b,
        output sum, cout, busy, done
    );

endinterface

// File: rtl/half_add_cell.sv
// Single-bit half adder; two of these plus an OR
// make the full-add cell of the serial datapath.
module half_add_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: one bit per cycle, LSB first,
// result and carry published together when the add completes.
module serial_add_ctrl
    import ser_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic ha0_s, ha0_c;
    logic ha1_s, ha1_c;
    logic bit_s, bit_c;
    logic accept, last;

    half_add_cell u_ha0 (
        .a (a_q[0]),
        .b (b_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_add_cell u_ha1 (
        .a (ha0_s),
        .b (c_q),
        .s (ha1_s),
        .c (ha1_c)
    );

    assign bit_s  = ha1_s;
    assign bit_c  = ha0_c | ha1_c;
    assign accept = (state_q == IDLE) && bus.start;
    assign last   = (state_q == RUN) && (cnt_q == CNT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter holds at its last value so it never wraps inside RUN.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        s_d    = s_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        c_d    = c_q;
        cout_d = cout_q;
        if (accept) begin
            a_d   = bus.op_a;
            b_d   = bus.op_b;
            s_d   = '0;
            cnt_d = '0;
            c_d   = 1'b0;
        end else if (state_q == RUN) begin
            a_d = {1'b0, a_q[WIDTH-1:1]};
            b_d = {1'b0, b_q[WIDTH-1:1]};
            s_d = {bit_s, s_q[WIDTH-1:1]};
            c_d = bit_c;
            if (last) begin
                sum_d  = {bit_s, s_q[WIDTH-1:1]};
                cout_d = bit_c;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Status flags are registered from the next state.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
// Expected sums come from plain integer addition.
module tb_serial_add_ctrl;
    import ser_add_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] lsum8 = '0;
    logic [15:0] lsum4 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(4)) bus4 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus8)
    );

    serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus4)
    );

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        c;
        string       nm;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input int w,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [16:0] mask;
        logic [16:0] full;
        mask = (17'd1 << w) - 17'd1;
        full = (17'(a) & mask) + (17'(b) & mask);
        return {full[w], 16'(full & mask)};
    endfunction

    function automatic logic [15:0] o_sum(input int w);
        return (w == 8) ? 16'(bus8.sum) : 16'(bus4.sum);
    endfunction

    function automatic logic o_cout(input int w);
        return (w == 8) ? bus8.cout : bus4.cout;
    endfunction

    function automatic logic o_busy(input int w);
        return (w == 8) ? bus8.busy : bus4.busy;
    endfunction

    function automatic logic o_done(input int w);
        return (w == 8) ? bus8.done : bus4.done;
    endfunction

    task automatic drive(input int w, input logic st,
                         input logic [15:0] a, input logic [15:0] b);
        if (w == 8) begin
            bus8.start = st;
            bus8.op_a  = a[7:0];
            bus8.op_b  = b[7:0];
        end else begin
            bus4.start = st;
            bus4.op_a  = a[3:0];
            bus4.op_b  = b[3:0];
        end
    endtask

    task automatic run_add(input int w, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] es,
                           input logic ec, input string nm);
        int lat = 0;
        int nb  = 0;
        bit seen = 0;
        logic [15:0] prev;
        prev = (w == 8) ? lsum8 : lsum4;
        @(negedge clk);
        drive(w, 1'b1, a, b);
        @(posedge clk);
        #1 drive(w, 1'b0, ~a, ~b);
        for (int i = 1; i <= w + 4 && !seen; i++) begin
            @(negedge clk);
            if (o_busy(w)) nb++;
            if (i == 1) check({nm, " hold"}, o_sum(w), prev);
            if (o_done(w)) begin
                seen = 1;
                lat  = i;
            end
        end
        check({nm, " latency"}, lat, w + 1);
        check({nm, " busy"}, nb, w);
        check({nm, " sum"}, o_sum(w), es);
        check({nm, " cout"}, o_cout(w), ec);
        if (seen) begin
            @(negedge clk);
            check({nm, " done_pulse"}, {o_done(w), o_busy(w)}, 2'b00);
        end
        if (w == 8) lsum8 = es;
        else lsum4 = es;
    endtask

    task automatic cont_test();
        logic [15:0] a1 = 16'h3C;
        logic [15:0] b1 = 16'hC4;
        logic [15:0] a2 = 16'h12;
        logic [15:0] b2 = 16'h34;
        logic [16:0] m1, m2;
        int nd = 0;
        int hold = 0;
        int t1 = 0;
        int t2 = 0;
        m1 = model(8, a1, b1);
        m2 = model(8, a2, b2);
        @(negedge clk);
        drive(8, 1'b1, a1, b1);
        for (int i = 0; i < 40 && nd < 2; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                nd++;
                if (nd == 1) begin
                    t1 = cyc;
                    check("cont1 sum", bus8.sum, m1[7:0]);
                    check("cont1 cout", bus8.cout, m1[16]);
                    drive(8, 1'b1, a2, b2);
                    hold = 1;
                end else begin
                    t2 = cyc;
                    check("cont2 sum", bus8.sum, m2[7:0]);
                    check("cont2 cout", bus8.cout, m2[16]);
                end
            end else if (hold > 0) begin
                hold--;
            end else begin
                drive(8, 1'b1, 16'($urandom), 16'($urandom));
            end
        end
        drive(8, 1'b0, 16'h0, 16'h0);
        check("cont done_count", nd, 2);
        check("cont period", t2 - t1, 10);
        lsum8 = {8'h0, m2[7:0]};
        repeat (2) @(negedge clk);
    endtask

    task automatic abort_test();
        int nd = 0;
        int nb = 0;
        @(negedge clk);
        drive(8, 1'b1, 16'h5A, 16'h3C);
        @(posedge clk);
        #1 drive(8, 1'b0, 16'h0, 16'h0);
        repeat (4) @(negedge clk);
        check("abort in_run", bus8.busy, 1'b1);
        #1 rst_n = 1'b0;
        drive(8, 1'b1, 16'hFF, 16'hFF);
        #1;
        check("abort sum", bus8.sum, 8'h00);
        check("abort flags", {bus8.cout, bus8.busy, bus8.done}, 3'b000);
        repeat (3) @(negedge clk);
        check("abort held", {bus8.busy, bus8.done}, 2'b00);
        drive(8, 1'b0, 16'h0, 16'h0);
        rst_n = 1'b1;
        lsum8 = '0;
        lsum4 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done) nd++;
            if (bus8.busy) nb++;
        end
        check("abort no_done", nd, 0);
        check("abort no_busy", nb, 0);
        run_add(8, 16'h80, 16'h80, 16'h00, 1'b1, "post_rst 80+80");
    endtask

    initial begin
        vec_t vecs[$];
        logic [15:0] ra, rb;
        logic [16:0] m;

        vecs.push_back('{8, 16'h5A, 16'h3C, 16'h96, 1'b0, "5A+3C"});
        vecs.push_back('{8, 16'hFF, 16'h01, 16'h00, 1'b1, "FF+01"});
        vecs.push_back('{8, 16'h00, 16'h00, 16'h00, 1'b0, "00+00"});
        vecs.push_back('{8, 16'h7F, 16'h01, 16'h80, 1'b0, "7F+01"});
        vecs.push_back('{8, 16'hAA, 16'h55, 16'hFF, 1'b0, "AA+55"});
        vecs.push_back('{8, 16'hFF, 16'hFF, 16'hFE, 1'b1, "FF+FF"});
        vecs.push_back('{4, 16'hF, 16'hF, 16'hE, 1'b1, "w4 F+F"});
        vecs.push_back('{4, 16'h0, 16'h1, 16'h1, 1'b0, "w4 0+1"});
        vecs.push_back('{4, 16'h8, 16'h8, 16'h0, 1'b1, "w4 8+8"});

        drive(8, 1'b0, 16'h0, 16'h0);
        drive(4, 1'b0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        check("reset sum8", bus8.sum, 8'h00);
        check("reset flags8", {bus8.cout, bus8.busy, bus8.done}, 3'b000);
        check("reset sum4", bus4.sum, 4'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset idle", {bus8.busy, bus8.done}, 2'b00);

        foreach (vecs[i])
            run_add(vecs[i].w, vecs[i].a, vecs[i].b,
                    vecs[i].s, vecs[i].c, vecs[i].nm);

        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            m  = model(8, ra, rb);
            run_add(8, ra, rb, m[15:0], m[16], "rand8");
        end
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom_range(0, 15));
            rb = 16'($urandom_range(0, 15));
            m  = model(4, ra, rb);
            run_add(4, ra, rb, m[15:0], m[16], "rand4");
        end

        cont_test();
        abort_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
